// File: rtl/wave_pkg.sv
// Shared definitions for the wave generator configuration path.
// Channel geometry, field-select encodings and the loader state encoding.
package wave_pkg;

    localparam int NUM_CHAN = 64;
    localparam int WORD_W   = 16;
    localparam int CHAN_W   = 6;
    localparam int BUS_W    = NUM_CHAN * WORD_W;

    localparam logic [1:0] FLD_AMP = 2'd0;
    localparam logic [1:0] FLD_OFS = 2'd1;
    localparam logic [1:0] FLD_PHW = 2'd2;
    localparam logic [1:0] FLD_RSV = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        SETTLE = 2'd2
    } state_t;

endpackage

// File: rtl/param_bank.sv
// One field's shadow bank (single-word writes) plus its active bus register.
// Active bus takes the whole shadow on the edge that ends an apply cycle; no backpressure.
module param_bank
    import wave_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [CHAN_W-1:0]   wr_chan,
    input  logic [WORD_W-1:0]   wr_data,
    input  logic                apply,
    output logic [BUS_W-1:0]    active
);

    // Packed so the shadow already has the bus layout: channel k at [16k+15:16k].
    logic [NUM_CHAN-1:0][WORD_W-1:0] shadow;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow <= '0;
        end else if (wr_en) begin
            shadow[wr_chan] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active <= '0;
        end else if (apply) begin
            active <= shadow;
        end
    end

endmodule

// File: rtl/wave_param_loader.sv
// Shadow-to-active parameter loader: commit copies all banks one edge after leaving IDLE,
// then writes are held off (wr_ready low) for SETTLE_CYCLES+1 cycles per commit.
module wave_param_loader
    import wave_pkg::*;
#(
    parameter int SETTLE_CYCLES = 8
)
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [CHAN_W-1:0]       wr_chan,
    input  logic [1:0]              wr_field,
    input  logic [WORD_W-1:0]       wr_data,
    input  logic                    commit,
    input  logic                    err_clr,
    output logic                    busy,
    output logic                    settled,
    output logic                    wr_err,
    output logic signed [BUS_W-1:0] amps,
    output logic [BUS_W-1:0]        offsets,
    output logic [BUS_W-1:0]        phasewords
);

    state_t     state;
    state_t     state_n;
    logic [7:0] cnt;
    logic [7:0] cnt_n;
    logic       pending;
    logic       pending_n;
    logic       settled_n;
    logic       wr_fire;
    logic       apply;

    assign busy     = (state != IDLE);
    assign wr_ready = !busy;
    assign wr_fire  = wr_valid && wr_ready;
    assign apply    = (state == APPLY);

    param_bank u_amp_bank (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_fire && (wr_field == FLD_AMP)),
        .wr_chan (wr_chan),
        .wr_data (wr_data),
        .apply   (apply),
        .active  (amps)
    );

    param_bank u_ofs_bank (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_fire && (wr_field == FLD_OFS)),
        .wr_chan (wr_chan),
        .wr_data (wr_data),
        .apply   (apply),
        .active  (offsets)
    );

    param_bank u_phw_bank (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_fire && (wr_field == FLD_PHW)),
        .wr_chan (wr_chan),
        .wr_data (wr_data),
        .apply   (apply),
        .active  (phasewords)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            pending <= 1'b0;
            settled <= 1'b1;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            pending <= pending_n;
            settled <= settled_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        pending_n = pending;
        settled_n = settled;
        unique case (state)
            IDLE: begin
                if (commit) begin
                    state_n = APPLY;
                end
            end
            APPLY: begin
                state_n   = SETTLE;
                cnt_n     = 8'(SETTLE_CYCLES - 1);
                settled_n = 1'b0;
                if (commit) begin
                    pending_n = 1'b1;
                end
            end
            SETTLE: begin
                if (cnt == 8'd0) begin
                    // A commit arriving on the exit cycle is folded into the re-apply.
                    if (pending || commit) begin
                        state_n   = APPLY;
                        pending_n = 1'b0;
                    end else begin
                        state_n   = IDLE;
                        settled_n = 1'b1;
                    end
                end else begin
                    cnt_n = cnt - 8'd1;
                    if (commit) begin
                        pending_n = 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_err <= 1'b0;
        end else if (wr_fire && (wr_field == FLD_RSV)) begin
            wr_err <= 1'b1;
        end else if (err_clr) begin
            wr_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wave_param_loader.sv
// Directed bench for wave_param_loader: event-time reference model compared every cycle,
// plus hand-computed literal expectations for the key scenarios.
module tb_wave_param_loader;

    localparam int S = 8;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           wr_valid = 1'b0;
    logic           wr_ready;
    logic [5:0]     wr_chan = '0;
    logic [1:0]     wr_field = '0;
    logic [15:0]    wr_data = '0;
    logic           commit = 1'b0;
    logic           err_clr = 1'b0;
    logic           busy;
    logic           settled;
    logic           wr_err;
    logic signed [1023:0] amps;
    logic [1023:0]  offsets;
    logic [1023:0]  phasewords;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    wave_param_loader #(.SETTLE_CYCLES(S)) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_chan    (wr_chan),
        .wr_field   (wr_field),
        .wr_data    (wr_data),
        .commit     (commit),
        .err_clr    (err_clr),
        .busy       (busy),
        .settled    (settled),
        .wr_err     (wr_err),
        .amps       (amps),
        .offsets    (offsets),
        .phasewords (phasewords)
    );

    always #5 clk = ~clk;

    // Reference model: shadow/active word arrays plus the edge numbers of the next copy and release.
    logic [15:0] m_sh  [3][64];
    logic [15:0] m_act [3][64];
    bit m_busy, m_settled, m_err, m_pend;
    int cyc = 0;
    int copy_at = -1;
    int free_at = -1;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int f = 0; f < 3; f++)
                for (int k = 0; k < 64; k++) begin
                    m_sh[f][k]  = 16'h0;
                    m_act[f][k] = 16'h0;
                end
            m_busy = 0; m_settled = 1; m_err = 0; m_pend = 0;
            copy_at = -1; free_at = -1;
        end else begin
            bit fire, start;
            cyc++;
            fire = wr_valid && !m_busy;
            if (cyc == copy_at) begin
                m_act = m_sh;
                m_settled = 0;
            end
            if (err_clr) m_err = 0;
            if (fire) begin
                if (wr_field == 2'd3) m_err = 1;
                else m_sh[wr_field][wr_chan] = wr_data;
            end
            start = 0;
            if (!m_busy) start = commit;
            else if (cyc == free_at) begin
                if (m_pend || commit) start = 1;
                else begin m_busy = 0; m_settled = 1; end
            end else if (commit) m_pend = 1;
            if (start) begin
                m_busy = 1; m_pend = 0;
                copy_at = cyc + 1;
                free_at = cyc + 1 + S;
            end
        end
    end

    function automatic logic [1023:0] pack(int f);
        logic [1023:0] r;
        for (int k = 0; k < 64; k++) r[16*k +: 16] = m_act[f][k];
        return r;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_bus(string nm, logic [1023:0] act, logic [1023:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            for (int k = 0; k < 64; k++) begin
                if (act[16*k +: 16] !== exp[16*k +: 16]) begin
                    $display("FAIL %s ch%0d got %h want %h at %0t", nm, k,
                             act[16*k +: 16], exp[16*k +: 16], $time);
                    break;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 32'(busy), 32'(m_busy));
            chk("wr_ready", 32'(wr_ready), 32'(!m_busy));
            chk("settled", 32'(settled), 32'(m_settled));
            chk("wr_err", 32'(wr_err), 32'(m_err));
            chk_bus("amps", amps, pack(0));
            chk_bus("offsets", offsets, pack(1));
            chk_bus("phasewords", phasewords, pack(2));
        end
    end

    task automatic wr(input logic [5:0] c, input logic [1:0] f, input logic [15:0] d,
                      input bit with_commit);
        int n;
        @(negedge clk);
        wr_valid = 1'b1; wr_chan = c; wr_field = f; wr_data = d;
        if (with_commit) commit = 1'b1;
        n = 0;
        while (!wr_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("wr_timeout", 32'(n), 32'd0);
        @(negedge clk);
        wr_valid = 1'b0;
        if (with_commit) commit = 1'b0;
    endtask

    task automatic pulse_commit();
        @(negedge clk); commit = 1'b1;
        @(negedge clk); commit = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("idle_timeout", 32'(n), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        logic [1023:0] eb;
        int n, s;

        // Reset values
        #2 reset = 1'b0;
        #1;
        chk_bus("rst_amps", amps, '0);
        chk_bus("rst_phw", phasewords, '0);
        chk("rst_settled", 32'(settled), 32'd1);
        chk("rst_wr_ready", 32'(wr_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        chk_en = 1'b1;

        // Single write and commit
        wr(6'd5, 2'd0, 16'h8001, 1'b0);
        pulse_commit();
        chk("busy_after_commit", 32'(busy), 32'd1);
        chk_bus("amps_before_copy", amps, '0);
        @(negedge clk);
        eb = '0;
        eb[95:80] = 16'h8001;
        chk_bus("amps_ch5_only", amps, eb);
        n = 0;
        while (!settled && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("settle_len", 32'(n), 32'd8);
        chk("busy_after_settle", 32'(busy), 32'd0);

        // Write together with commit
        wr(6'd63, 2'd2, 16'h1234, 1'b1);
        @(negedge clk);
        chk("phw_ch63", 32'(phasewords[1023:1008]), 32'h1234);
        wait_idle();

        // Commit during SETTLE with a stalled write
        pulse_commit();
        n = 0; s = 0;
        fork
            wr(6'd1, 2'd1, 16'hABCD, 1'b0);
            begin
                repeat (3) @(negedge clk);
                pulse_commit();
            end
            begin
                while (busy && n < 100) begin
                    n++;
                    if (settled) s++;
                    @(negedge clk);
                end
            end
        join
        chk("busy_run_len", 32'(n), 32'd18);
        chk("settled_high_in_run", 32'(s), 32'd1);
        chk("ofs_ch1_uncommitted", 32'(offsets[31:16]), 32'h0);
        pulse_commit();
        @(negedge clk);
        chk("ofs_ch1_committed", 32'(offsets[31:16]), 32'hABCD);
        wait_idle();

        // Reserved field
        wr(6'd7, 2'd3, 16'hFFFF, 1'b0);
        chk("rsv_sets_err", 32'(wr_err), 32'd1);
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        chk("err_cleared", 32'(wr_err), 32'd0);
        @(negedge clk);
        wr_valid = 1'b1; wr_field = 2'd3; wr_chan = 6'd7; wr_data = 16'hFFFF; err_clr = 1'b1;
        @(negedge clk);
        wr_valid = 1'b0; err_clr = 1'b0;
        chk("set_beats_clear", 32'(wr_err), 32'd1);
        pulse_commit();
        wait_idle();
        chk("rsv_no_shadow_amp", 32'(amps[127:112]), 32'h0);
        chk("rsv_no_shadow_ofs", 32'(offsets[127:112]), 32'h0);

        // Reset mid-SETTLE with a pending commit
        pulse_commit();
        pulse_commit();
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk_bus("midrst_amps", amps, '0);
        chk_bus("midrst_ofs", offsets, '0);
        chk("midrst_settled", 32'(settled), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_wr_ready", 32'(wr_ready), 32'd1);
        chk("midrst_wr_err", 32'(wr_err), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (12) @(negedge clk);
        chk("pending_dropped", 32'(busy), 32'd0);
        chk("post_rst_settled", 32'(settled), 32'd1);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
